// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data RAM between VGA reads, CPU reads/writes and
// button writes: VGA first, a burst limit to protect the others, CPU/BTN round-robin.
module mem_arbiter #(
  parameter int          VGA_BURST = 4,
  parameter logic [31:0] BTN_ADDR  = 32'h0000_0FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [31:0] vga_rdata,
  input  logic        btn_req,
  input  logic [31:0] btn_wdata,
  output logic        btn_gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VGA} tag_t;

  localparam logic [3:0] BURST_MAX = 4'(VGA_BURST);

  logic       rr_q;
  logic [3:0] burst_q;
  tag_t       tag_q;

  logic w_other_pend;
  logic w_force;
  logic w_vga_win;
  logic w_cpu_win;
  logic w_btn_win;

  assign w_other_pend = cpu_req | btn_req;
  // Once VGA has used its burst allowance, a waiting CPU/BTN takes this slot.
  assign w_force      = (burst_q == BURST_MAX) && w_other_pend;
  assign w_vga_win    = vga_req && !w_force;
  assign w_cpu_win    = !w_vga_win && cpu_req && (!btn_req || !rr_q);
  assign w_btn_win    = !w_vga_win && btn_req && (!cpu_req || rr_q);

  assign vga_gnt = w_vga_win;
  assign cpu_gnt = w_cpu_win;
  assign btn_gnt = w_btn_win;

  // NOTE: every output gets a default before the case-like chain, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_sel   = 4'd0;
    mem_wdata = 32'd0;
    if (w_vga_win) begin
      mem_en   = 1'b1;
      mem_addr = vga_addr;
      mem_sel  = 4'b1111;
    end else if (w_cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_sel   = cpu_we ? cpu_sel : 4'b1111;
      mem_wdata = cpu_wdata;
    end else if (w_btn_win) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = BTN_ADDR;
      mem_sel   = 4'b1111;
      mem_wdata = btn_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= 1'b0;
      burst_q <= 4'd0;
      tag_q   <= TAG_NONE;
    end else begin
      if (w_cpu_win)      rr_q <= 1'b1;
      else if (w_btn_win) rr_q <= 1'b0;

      if (w_vga_win && w_other_pend) burst_q <= burst_q + 4'd1;
      else                           burst_q <= 4'd0;

      if (w_vga_win)                tag_q <= TAG_VGA;
      else if (w_cpu_win && !cpu_we) tag_q <= TAG_CPU;
      else                          tag_q <= TAG_NONE;
    end
  end

  assign cpu_rvalid = (tag_q == TAG_CPU);
  assign vga_rvalid = (tag_q == TAG_VGA);
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected read returns into
// per-requester queues, a negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam logic [31:0] BTN_ADDR = 32'h0000_0FFC;

  typedef enum int {G_NONE, G_VGA, G_CPU, G_BTN} gnt_t;
  typedef struct { int due; logic [31:0] data; } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_sel = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        vga_req = 1'b0;
  logic [31:0] vga_addr = '0;
  logic        vga_gnt, vga_rvalid;
  logic [31:0] vga_rdata;
  logic        btn_req = 1'b0;
  logic [31:0] btn_wdata = '0;
  logic        btn_gnt;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  rd_t cq[$];
  rd_t vq[$];

  mem_arbiter #(.VGA_BURST(4), .BTN_ADDR(BTN_ADDR)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .vga_rdata(vga_rdata),
    .btn_req(btn_req), .btn_wdata(btn_wdata), .btn_gnt(btn_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: words 0..15 preloaded with A000_0000+index, byte-enabled writes.
  logic [31:0] ram [0:1023];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= (i < 16) ? 32'hA000_0000 + 32'(i) : 32'd0;
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_sel[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[11:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each negedge, a requester's rvalid must be high exactly when its
  // queue head is due this cycle, and the data must match.
  initial begin
    forever begin
      @(negedge clk);
      if (cq.size() > 0 && cq[0].due == cyc) begin
        check("cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("cpu_rdata", cpu_rdata, cq[0].data);
        void'(cq.pop_front());
      end else begin
        check("cpu_rvalid_idle", {31'd0, cpu_rvalid}, 32'd0);
      end
      if (vq.size() > 0 && vq[0].due == cyc) begin
        check("vga_rvalid", {31'd0, vga_rvalid}, 32'd1);
        check("vga_rdata", vga_rdata, vq[0].data);
        void'(vq.pop_front());
      end else begin
        check("vga_rvalid_idle", {31'd0, vga_rvalid}, 32'd0);
      end
    end
  end

  task automatic step(input logic vr, input logic [31:0] va,
                      input logic cr, input logic cw, input logic [31:0] ca,
                      input logic [3:0] cs, input logic [31:0] cd,
                      input logic br, input logic [31:0] bd,
                      input gnt_t eg, input logic [31:0] edata);
    logic [2:0]  e_gnt;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_sel;
    rd_t         r;
    @(posedge clk); #1;
    vga_req = vr; vga_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_sel = cs; cpu_wdata = cd;
    btn_req = br; btn_wdata = bd;
    #1;
    e_gnt = 3'b000; e_en = 1'b1; e_we = 1'b0; e_addr = 32'd0; e_sel = 4'b1111; e_wd = 32'd0;
    case (eg)
      G_VGA: begin e_gnt = 3'b100; e_addr = va; end
      G_CPU: begin e_gnt = 3'b010; e_we = cw; e_addr = ca; e_sel = cw ? cs : 4'b1111; e_wd = cd; end
      G_BTN: begin e_gnt = 3'b001; e_we = 1'b1; e_addr = BTN_ADDR; e_wd = bd; end
      default: begin e_en = 1'b0; e_sel = 4'd0; end
    endcase
    check("grant_vcb", {29'd0, vga_gnt, cpu_gnt, btn_gnt}, {29'd0, e_gnt});
    check("mem_en_we", {30'd0, mem_en, mem_we}, {30'd0, e_en, e_we});
    check("mem_addr", mem_addr, e_addr);
    check("mem_sel", {28'd0, mem_sel}, {28'd0, e_sel});
    if (e_we) check("mem_wdata", mem_wdata, e_wd);
    r.due = cyc + 1;
    r.data = edata;
    if (eg == G_VGA) vq.push_back(r);
    if (eg == G_CPU && !cw) cq.push_back(r);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE, 0);
  endtask

  initial begin
    // Reset: rvalids low, grants still combinational.
    cpu_req = 1'b1; cpu_addr = 32'h0;
    #1;
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_vga_rvalid", {31'd0, vga_rvalid}, 32'd0);
    check("rst_cpu_gnt_comb", {31'd0, cpu_gnt}, 32'd1);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // CPU alone: write then read back.
    step(0, 0, 1, 1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 0, 0, G_CPU, 0);
    step(0, 0, 1, 0, 32'h100, 4'b0000, 0, 0, 0, G_CPU, 32'hDEAD_BEEF);
    idle();

    // Reset between read grant and its return.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    #1 check("midrd_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    #1 rst = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    check("midrd_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // CPU + BTN, VGA idle: C,B,C,B from reset round-robin state.
    step(0, 0, 1, 0, 32'h100, 0, 0, 1, 32'h0000_0011, G_CPU, 32'hDEAD_BEEF);
    step(0, 0, 1, 0, 32'h100, 0, 0, 1, 32'h0000_0011, G_BTN, 0);
    step(0, 0, 1, 0, 32'h100, 0, 0, 1, 32'h0000_0022, G_CPU, 32'hDEAD_BEEF);
    step(0, 0, 1, 0, 32'h100, 0, 0, 1, 32'h0000_0022, G_BTN, 0);
    step(0, 0, 1, 0, BTN_ADDR, 0, 0, 0, 0, G_CPU, 32'h0000_0022);

    // Byte-enable merge.
    step(0, 0, 1, 1, 32'h200, 4'b1111, 32'hFFFF_FFFF, 0, 0, G_CPU, 0);
    step(0, 0, 1, 1, 32'h200, 4'b0011, 32'h1122_3344, 0, 0, G_CPU, 0);
    step(0, 0, 1, 0, 32'h200, 0, 0, 0, 0, G_CPU, 32'hFFFF_3344);
    idle();

    // VGA alone, back-to-back.
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, G_VGA, 32'hA000_0000);
    step(1, 32'h4, 0, 0, 0, 0, 0, 0, 0, G_VGA, 32'hA000_0001);
    step(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, G_VGA, 32'hA000_0002);

    // VGA + CPU continuous: V,V,V,V,C twice (burst count must start at 0).
    begin
      logic [31:0] va;
      va = 32'h0;
      for (int k = 0; k < 10; k++) begin
        if (k % 5 == 4) begin
          step(1, va, 1, 0, 32'h100, 0, 0, 0, 0, G_CPU, 32'hDEAD_BEEF);
        end else begin
          step(1, va, 1, 0, 32'h100, 0, 0, 0, 0, G_VGA, 32'hA000_0000 + (va >> 2));
          va = va + 32'd4;
        end
      end
    end
    idle();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk) rst = 1'b1;

    // All three from reset: V x4, C, V x4, B.
    begin
      logic [31:0] va;
      va = 32'h0;
      for (int k = 0; k < 10; k++) begin
        if (k == 4) begin
          step(1, va, 1, 0, 32'h100, 0, 0, 1, 32'h0000_0055, G_CPU, 32'hDEAD_BEEF);
        end else if (k == 9) begin
          step(1, va, 1, 0, 32'h100, 0, 0, 1, 32'h0000_0055, G_BTN, 0);
        end else begin
          step(1, va, 1, 0, 32'h100, 0, 0, 1, 32'h0000_0055, G_VGA, 32'hA000_0000 + (va >> 2));
          va = va + 32'd4;
        end
      end
    end
    idle();
    step(0, 0, 1, 0, BTN_ADDR, 0, 0, 0, 0, G_CPU, 32'h0000_0055);
    idle();
    idle();

    check("cpu_q_drained", 32'(cq.size()), 32'd0);
    check("vga_q_drained", 32'(vq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port data RAM between three requesters: the CPU data port (read/write), the VGA frame reader (read-only), and the button sampler (write-only, fixed address). It sits between `mips`/`vga`/`btn_module` and `ram`, issuing one memory command per cycle. Read data returns one cycle later, tagged to the requester that issued it. VGA has priority, bounded by a burst limit so the CPU and buttons cannot starve.

## Interface
- `VGA_BURST`, 4: max consecutive VGA grants while another requester is pending (1..15)
- `BTN_ADDR`, 32'h0000_0FFC: word address written by button requests
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `cpu_req` in 1: CPU request, held until `cpu_gnt`
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in 32: byte address
- `cpu_sel` in 4: byte enables (writes)
- `cpu_wdata` in 32: write data
- `cpu_gnt` out 1: request accepted this cycle
- `cpu_rvalid` out 1: `cpu_rdata` valid (one-cycle pulse)
- `cpu_rdata` out 32: read data
- `vga_req` in 1, `vga_addr` in 32: VGA read request and address
- `vga_gnt` out 1, `vga_rvalid` out 1, `vga_rdata` out 32: same meaning as CPU
- `btn_req` in 1, `btn_wdata` in 32: button write request and data
- `btn_gnt` out 1: button write accepted
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_sel` out 4, `mem_wdata` out 32: RAM command
- `mem_rdata` in 32: RAM read data, valid the cycle after a read command

## Operation
- At most one grant per cycle. Grants are combinational from current requests plus registered state; the RAM command is the granted requester's fields muxed combinationally. No grant: `mem_en`=0, `mem_we`=0, other mem outputs 0.
- Priority: VGA > {CPU, BTN}, except when forced (below).
- CPU vs BTN: round-robin via 1-bit `rr_q` (0 = CPU favoured). After a CPU grant `rr_q`←1; after a BTN grant `rr_q`←0. Only one pending: it wins regardless of `rr_q`.
- Burst limit: 4-bit `burst_q` counts consecutive VGA grants. It increments on a VGA grant while `cpu_req|btn_req`, and clears on any non-VGA grant or when neither is pending. When `burst_q`==`VGA_BURST` and CPU or BTN pending, that cycle grants CPU/BTN (per `rr_q`) instead of VGA.
- BTN write: `mem_addr`=`BTN_ADDR`, `mem_sel`=4'b1111, `mem_we`=1, `mem_wdata`=`btn_wdata`.
- CPU write: `mem_we`=1 with `cpu_sel`/`cpu_wdata`. CPU read: `mem_we`=0, `mem_sel`=4'b1111.
- Read tag: 2-bit `tag_q` ∈ {NONE, CPU, VGA} registered on each grant (read → requester, write/no grant → NONE). Next cycle `cpu_rvalid`/`vga_rvalid` = (`tag_q` == CPU/VGA), and both `*_rdata` = `mem_rdata` (unqualified; consumers use rvalid).
- A requester may issue back-to-back: a new grant in the cycle its previous rvalid is high is legal.
- Requesters must hold req/fields stable until gnt. Dropping req without gnt is allowed; no command results.

## Timing
- Reset (`rst`=0, async): `rr_q`=0, `burst_q`=0, `tag_q`=NONE. So `cpu_rvalid`=`vga_rvalid`=0 immediately. Grants and mem outputs follow requests combinationally, with no registered output.
- Grant latency: 0 cycles (gnt in same cycle as req if it wins). Read latency: rvalid exactly 1 cycle after gnt.
- Reset asserted between read grant and return: no rvalid is produced for that read.
- Throughput: 1 command/cycle. Worst-case CPU wait with VGA continuous and BTN continuous: 2·`VGA_BURST`+1 cycles.
- Simultaneous all-three requests from reset: VGA granted `VGA_BURST` cycles, then CPU, then VGA again (counter cleared), then after next burst BTN.

## Test plan
- Reset mid-read: CPU read granted, `rst` low before next edge → `cpu_rvalid` stays 0; after release all regs at reset values.
- CPU alone: write 32'hDEAD_BEEF sel 4'b1111 to 0x100, then read 0x100 → gnt same cycle each, `cpu_rvalid` one cycle after read gnt, data 32'hDEAD_BEEF; `vga_rvalid` stays 0.
- VGA continuous + CPU continuous reads, `VGA_BURST`=4 → grant pattern V,V,V,V,C repeating; each `vga_rvalid`/`cpu_rvalid` matches its grant one cycle later.
- CPU and BTN together, VGA idle → alternating C,B,C,B starting with C; RAM at `BTN_ADDR` holds latest `btn_wdata`, `mem_sel`=4'b1111.
- Byte-enable write: CPU writes 32'h1122_3344 sel 4'b0011 over 32'hFFFF_FFFF → read returns 32'hFFFF_3344.
- Back-to-back VGA reads 0x0,0x4,0x8 with VGA alone → `vga_rvalid` high three consecutive cycles, data in address order, `burst_q` stays 0.
